// File: rtl/if_fetch_unit.sv
// if_fetch_unit: LC-3b instruction-fetch stage.
// Owns the fetch PC, issues hold-until-response word reads, buffers returned
// words in a small FIFO and shows the FIFO head to the IF/ID register.
// A redirect clears the FIFO. If a read is already in flight, the unit waits
// in FLUSH for that read's response, discards it, and then resumes at the
// latched target.
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [15:0]   r_target, w_target_nxt;
  logic          r_pending, w_pending_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [15:0]   r_fifo_pc    [DEPTH];
  logic [15:0]   r_fifo_instr [DEPTH];

  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_redir_pc;
  logic [15:0]   w_reset_pc;

  // Instruction addresses are halfword aligned, so bit 0 is dropped.
  assign w_redir_pc  = redirect_pc & 16'hFFFE;
  assign w_reset_pc  = RESET_PC & 16'hFFFE;
  assign mem_address = r_fetch_pc;

  // Next-state, FIFO bookkeeping and output decode; reset forces the outputs quiet.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    w_pending_nxt  = 1'b0;
    w_count_nxt    = r_count;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    mem_read       = 1'b0;
    w_resp         = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    if_valid       = 1'b0;
    if_pc          = 16'h0000;
    if_instr       = 16'h0000;

    if (!reset) begin
      // While a read is pending it stays asserted, even if the FIFO is full.
      mem_read = (r_state == ST_FLUSH) || r_pending || (r_count < DEPTH_C);
      w_resp   = mem_read && mem_resp;

      // A redirect hides the head in the same cycle, so the IF/ID register cannot load a wrong-path word.
      if_valid = (r_count != '0) && !redirect;
      if (if_valid) begin
        if_pc    = r_fifo_pc[r_rd_ptr];
        if_instr = r_fifo_instr[r_rd_ptr];
      end

      w_pop  = if_valid && id_ready;
      w_push = w_resp && (r_state == ST_RUN) && !redirect;

      if (w_push) begin
        w_wr_ptr_nxt   = r_wr_ptr + PW'(1);
        w_fetch_pc_nxt = r_fetch_pc + 16'd2;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end
      w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

      case (r_state)
        ST_RUN: begin
          w_pending_nxt = mem_read && !mem_resp && !redirect;
          if (redirect) begin
            if (mem_read && !mem_resp) begin
              // The in-flight read cannot be aborted; wait for it in FLUSH.
              w_state_nxt  = ST_FLUSH;
              w_target_nxt = w_redir_pc;
            end else begin
              w_fetch_pc_nxt = w_redir_pc;
            end
          end
        end
        ST_FLUSH: begin
          if (w_resp) begin
            w_state_nxt    = ST_RUN;
            w_fetch_pc_nxt = redirect ? w_redir_pc : r_target;
          end else if (redirect) begin
            w_target_nxt = w_redir_pc;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase

      if (redirect) begin
        w_count_nxt  = '0;
        w_rd_ptr_nxt = '0;
        w_wr_ptr_nxt = '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC, redirect target, outstanding-read flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= w_reset_pc;
      r_target   <= w_reset_pc;
      r_pending  <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
      r_pending  <= w_pending_nxt;
      r_count    <= w_count_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
    end
  end

  // FIFO storage. It has no reset because entries are only shown when the count is nonzero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
      r_fifo_instr[r_wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined LC-3b.
- Owns the fetch PC and issues 16-bit word reads to instruction memory using a hold-until-response handshake.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to the IF/ID pipeline register. That register is loaded when `id_ready` is high.
- Handles branch/jump redirects, including one outstanding read that cannot be aborted. When no instruction is available it emits a NOP (0x0000, BR never).

Parameters:
- DEPTH, 2, instruction FIFO entries. Power of two, at least 2.
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_read  output  1  instruction-memory read request.
- mem_address  output  16  byte address of the read; bit 0 is always 0.
- mem_resp  input  1  read complete; mem_rdata is valid this cycle.
- mem_rdata  input  16  instruction word.
- redirect  input  1  taken branch/jump from a later stage; flush and refetch.
- redirect_pc  input  16  target PC; bit 0 is ignored and forced to 0.
- id_ready  input  1  IF/ID register loads this cycle (pop when if_valid).
- if_valid  output  1  if_instr/if_pc hold a real instruction.
- if_pc  output  16  PC of the head instruction; 0 when !if_valid.
- if_instr  output  16  head instruction; 16'h0000 (NOP) when !if_valid.

Behaviour:
- Reset (the cycle reset is high; takes effect at the next edge):
  - fetch_pc = RESET_PC; FIFO count = 0; state = RUN.
  - While reset is high: mem_read = 0, if_valid = 0, if_instr = 0, if_pc = 0.
  - Reset mid-read abandons the read; mem_resp is ignored while reset is high.
- State RUN:
  - mem_read = (count < DEPTH).
  - mem_address = fetch_pc, held stable until mem_resp.
  - On mem_resp: push {fetch_pc, mem_rdata}; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000.
  - mem_read may stay high back-to-back, giving one word per response.
- State FLUSH:
  - mem_read = 1 at the stale address until mem_resp. The response data is discarded and never pushed.
  - On mem_resp: state = RUN; fetch_pc = the latched redirect target.
- Redirect (redirect = 1 in cycle N):
  - FIFO is cleared at edge N; if_valid is forced to 0 combinationally during cycle N; any pop in N is ignored.
  - If in RUN with mem_read = 1 and mem_resp = 0: state becomes FLUSH; the target is latched.
  - If mem_resp = 1 in N: data is discarded; fetch_pc = target; state stays RUN.
  - If no read is outstanding: fetch_pc = target; stays RUN. A new request appears at cycle N+1.
  - Redirect while in FLUSH: the latched target is overwritten by the newest one.
- Output and FIFO:
  - The FIFO head is shown directly.
  - Latency: mem_resp in cycle N gives if_valid = 1 in cycle N+1.
  - Pop when if_valid and id_ready. Push and pop in the same cycle keep count unchanged.
  - Push never overflows, because a request is only issued when count < DEPTH and at most one read is outstanding.
  - If count reaches DEPTH while mem_read is high with no mem_resp: mem_read stays high and the address stays held, so the request is never withdrawn.
  - Read/write pointers wrap modulo DEPTH.
- Empty FIFO: if_valid = 0, if_instr = 16'h0000, if_pc = 0. id_ready is ignored.
- No X on any output after the first reset edge.

Test Plan:
1. Reset, then a memory with 1-cycle response returning 0x1111, 0x2222, 0x3333, with id_ready = 1 -> mem_address sequence 0x0000, 0x0002, 0x0004; the IF/ID side receives (0x0000, 0x1111), (0x0002, 0x2222), (0x0004, 0x3333), each one cycle after its mem_resp.
2. id_ready = 0 with DEPTH = 2 -> after two responses, mem_read drops to 0 with fetch_pc = 0x0004. Raise id_ready -> one pop per cycle; mem_read reasserts at 0x0004 once count < 2.
3. Redirect to 0x3000 while a read of 0x0006 is outstanding (mem_resp 3 cycles later with 0xDEAD) -> mem_read holds 0x0006; 0xDEAD is never presented; the next request is 0x3000; if_valid = 0 throughout.
4. Redirect to 0x4001 in the same cycle as mem_resp -> response dropped; next mem_address = 0x4000; FIFO empty and if_instr = 0x0000 the following cycle.
5. Two redirects (0x5000, then 0x6000) during FLUSH -> after the stale response, fetch resumes at 0x6000 only.
6. Fetch at 0xFFFE, response 0xABCD -> output (0xFFFE, 0xABCD); next mem_address = 0x0000. Reset asserted mid-read -> mem_read = 0 that cycle; fetch restarts at RESET_PC.
